// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution: decodes taken/not-taken from the comparator, redirects
// fetch on a mispredict, and owns the 2-bit-counter BHT and the branch statistics.
module branch_resolve_unit #(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 16,
  parameter int INDEX_LSB   = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] if_pc,
  output logic            if_pred_taken,
  input  logic            ex_valid,
  input  logic            ex_is_branch,
  input  logic [2:0]      ex_funct3,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_target,
  input  logic            ex_pred_taken,
  output logic            BrUn,
  input  logic            BrEq,
  input  logic            BrLt,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flush,
  output logic            illegal_branch,
  output logic [31:0]     branch_count,
  output logic [31:0]     mispredict_count
);
  localparam int IDX_W = $clog2(BHT_ENTRIES);

  logic [1:0]      bht_q [BHT_ENTRIES];
  logic [1:0]      bht_d [BHT_ENTRIES];
  logic            redirect_valid_q, redirect_valid_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
  logic            illegal_q, illegal_d;
  logic [31:0]     branch_count_q, branch_count_d;
  logic [31:0]     mispredict_count_q, mispredict_count_d;

  logic             resolve, legal, taken, mispredict;
  logic [IDX_W-1:0] if_idx, ex_idx;
  logic [1:0]       ex_ctr;
  logic             unused_pc_bits;

  assign BrUn   = ex_funct3[1];
  assign if_idx = if_pc[INDEX_LSB +: IDX_W];
  assign ex_idx = ex_pc[INDEX_LSB +: IDX_W];
  assign ex_ctr = bht_q[ex_idx];

  // No bypass: a lookup in the update cycle sees the pre-update counter.
  assign if_pred_taken = bht_q[if_idx][1];

  // The EX slot during a redirect cycle is wrong-path and must not resolve.
  assign resolve    = ex_valid & ex_is_branch & ~redirect_valid_q;
  assign legal      = (ex_funct3[2:1] != 2'b01);
  assign mispredict = resolve & legal & (taken != ex_pred_taken);

  assign unused_pc_bits = ^{if_pc, ex_pc};

  always_comb begin
    taken = 1'b0;
    case (ex_funct3)
      3'b000:         taken = BrEq;
      3'b001:         taken = ~BrEq;
      3'b100, 3'b110: taken = BrLt;
      3'b101, 3'b111: taken = ~BrLt;
      default:        taken = 1'b0;
    endcase
  end

  always_comb begin
    bht_d              = bht_q;
    redirect_valid_d   = mispredict;
    redirect_pc_d      = redirect_pc_q;
    illegal_d          = resolve & ~legal;
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;
    if (mispredict) begin
      redirect_pc_d      = taken ? ex_target : ex_pc + XLEN'(4);
      mispredict_count_d = mispredict_count_q + 32'd1;
    end
    if (resolve && legal) begin
      branch_count_d = branch_count_q + 32'd1;
      if (taken && (ex_ctr != 2'b11)) begin
        bht_d[ex_idx] = ex_ctr + 2'd1;
      end else if (!taken && (ex_ctr != 2'b00)) begin
        bht_d[ex_idx] = ex_ctr - 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        bht_q[i] <= 2'b01;
      end
      redirect_valid_q   <= 1'b0;
      redirect_pc_q      <= '0;
      illegal_q          <= 1'b0;
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      bht_q              <= bht_d;
      redirect_valid_q   <= redirect_valid_d;
      redirect_pc_q      <= redirect_pc_d;
      illegal_q          <= illegal_d;
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  assign redirect_valid   = redirect_valid_q;
  assign flush            = redirect_valid_q;
  assign redirect_pc      = redirect_pc_q;
  assign illegal_branch   = illegal_q;
  assign branch_count     = branch_count_q;
  assign mispredict_count = mispredict_count_q;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: directed branches push expected
// redirect/illegal events; a negedge monitor pops and checks them.
module tb_branch_resolve_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] if_pc;
  logic        if_pred_taken;
  logic        ex_valid, ex_is_branch, ex_pred_taken;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_pc, ex_target;
  logic        BrUn, BrEq, BrLt;
  logic        redirect_valid, flush, illegal_branch;
  logic [31:0] redirect_pc, branch_count, mispredict_count;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    logic [31:0] pc;
    int          at;
  } redir_t;
  redir_t redir_q[$];
  int     ill_q[$];

  branch_resolve_unit dut (
    .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
    .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_funct3(ex_funct3),
    .ex_pc(ex_pc), .ex_target(ex_target), .ex_pred_taken(ex_pred_taken),
    .BrUn(BrUn), .BrEq(BrEq), .BrLt(BrLt),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush(flush),
    .illegal_branch(illegal_branch), .branch_count(branch_count),
    .mispredict_count(mispredict_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every observed pulse must match the head of its queue, in the right cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (redirect_valid || flush) begin
        check("flush_eq_redirect", {31'd0, flush}, {31'd0, redirect_valid});
      end
      if (redirect_valid) begin
        if (redir_q.size() == 0) begin
          check("unexpected_redirect", 32'd1, 32'd0);
        end else begin
          redir_t r;
          r = redir_q.pop_front();
          check("redirect_pc", redirect_pc, r.pc);
          check("redirect_cycle", cyc, r.at);
        end
      end
      if (illegal_branch) begin
        if (ill_q.size() == 0) begin
          check("unexpected_illegal", 32'd1, 32'd0);
        end else begin
          int at;
          at = ill_q.pop_front();
          check("illegal_cycle", cyc, at);
        end
      end
    end
  end

  task automatic idle();
    ex_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  // Present one branch for one cycle; exp_* are hand-computed expectations.
  task automatic issue(input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] tgt,
                       input logic pred, input logic eq, input logic lt,
                       input logic exp_redir, input logic [31:0] exp_pc, input logic exp_ill);
    ex_valid = 1'b1; ex_is_branch = 1'b1; ex_funct3 = f3; ex_pc = pc;
    ex_target = tgt; ex_pred_taken = pred; BrEq = eq; BrLt = lt;
    if (exp_redir) redir_q.push_back('{pc: exp_pc, at: cyc + 1});
    if (exp_ill) ill_q.push_back(cyc + 1);
    @(posedge clk); #1;
    ex_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; if_pc = 32'h0; ex_valid = 1'b0; ex_is_branch = 1'b0;
    ex_funct3 = 3'b000; ex_pc = 32'h0; ex_target = 32'h0; ex_pred_taken = 1'b0;
    BrEq = 1'b0; BrLt = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset state
    check("rst_pred", {31'd0, if_pred_taken}, 32'd0);
    check("rst_redirect", {31'd0, redirect_valid}, 32'd0);
    check("rst_flush", {31'd0, flush}, 32'd0);
    check("rst_illegal", {31'd0, illegal_branch}, 32'd0);
    check("rst_redirect_pc", redirect_pc, 32'h0);
    check("rst_bcount", branch_count, 32'd0);
    check("rst_mcount", mispredict_count, 32'd0);

    // BHT training on 0x40 (index 0), predictions given as correct
    if_pc = 32'h40;
    ex_valid = 1'b1; ex_is_branch = 1'b1; ex_funct3 = 3'b000; ex_pc = 32'h40;
    ex_target = 32'h80; ex_pred_taken = 1'b1; BrEq = 1'b1; BrLt = 1'b0;
    #1 check("bht_pre_update", {31'd0, if_pred_taken}, 32'd0);
    issue(3'b000, 32'h40, 32'h80, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    check("bht_after_1", {31'd0, if_pred_taken}, 32'd1);
    issue(3'b000, 32'h40, 32'h80, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    issue(3'b000, 32'h40, 32'h80, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    check("bht_after_3", {31'd0, if_pred_taken}, 32'd1);
    check("bcount_train", branch_count, 32'd3);
    check("mcount_train", mispredict_count, 32'd0);

    // BEQ taken, predicted not-taken
    issue(3'b000, 32'h100, 32'h200, 1'b0, 1'b1, 1'b0, 1'b1, 32'h200, 1'b0);
    idle(); idle();
    check("bcount_beq", branch_count, 32'd4);
    check("mcount_beq", mispredict_count, 32'd1);

    // BGEU taken, correctly predicted; BrUn combinational
    ex_funct3 = 3'b111; #1 check("brun_bgeu", {31'd0, BrUn}, 32'd1);
    ex_funct3 = 3'b110; #1 check("brun_bltu", {31'd0, BrUn}, 32'd1);
    ex_funct3 = 3'b101; #1 check("brun_bge", {31'd0, BrUn}, 32'd0);
    issue(3'b111, 32'h104, 32'h300, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    idle();
    check("bcount_bgeu", branch_count, 32'd5);
    check("mcount_bgeu", mispredict_count, 32'd1);

    // Fall-through wraps to zero
    issue(3'b100, 32'hFFFF_FFFC, 32'h1000, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 1'b0);
    idle();
    issue(3'b001, 32'h200, 32'h300, 1'b0, 1'b0, 1'b0, 1'b1, 32'h300, 1'b0);
    idle();
    issue(3'b101, 32'h300, 32'h700, 1'b1, 1'b0, 1'b1, 1'b1, 32'h304, 1'b0);
    idle();
    issue(3'b110, 32'h400, 32'h500, 1'b0, 1'b0, 1'b1, 1'b1, 32'h500, 1'b0);
    idle();
    check("bcount_mix", branch_count, 32'd9);
    check("mcount_mix", mispredict_count, 32'd5);

    // Mispredict then back-to-back branch in the redirect cycle (suppressed)
    issue(3'b000, 32'h600, 32'h700, 1'b1, 1'b0, 1'b0, 1'b1, 32'h604, 1'b0);
    issue(3'b000, 32'h820, 32'h900, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    idle();
    check("bcount_suppr", branch_count, 32'd10);
    check("mcount_suppr", mispredict_count, 32'd6);
    if_pc = 32'h820;
    #1 check("bht_suppr", {31'd0, if_pred_taken}, 32'd0);

    // Illegal funct3
    issue(3'b010, 32'h900, 32'hA00, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    idle();
    issue(3'b011, 32'h904, 32'hA00, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    idle();
    check("bcount_ill", branch_count, 32'd10);
    check("mcount_ill", mispredict_count, 32'd6);

    // Reset in the middle of a redirect pulse
    issue(3'b000, 32'hA00, 32'hB00, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    check("pulse_before_rst", {31'd0, redirect_valid}, 32'd1);
    #1 rst_n = 1'b0;
    #1 check("pulse_killed", {31'd0, redirect_valid}, 32'd0);
    check("flush_killed", {31'd0, flush}, 32'd0);
    check("bcount_rst", branch_count, 32'd0);
    check("mcount_rst", mispredict_count, 32'd0);
    if_pc = 32'h40;
    #1 check("bht_rst", {31'd0, if_pred_taken}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    idle(); idle();

    check("redir_q_drained", redir_q.size(), 32'd0);
    check("ill_q_drained", ill_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
EX-stage consumer of the branch comparator.
- Drives BrUn to the comparator from the branch funct3.
- Consumes BrEq/BrLt and resolves taken/not-taken.
- Compares the outcome with the IF-stage prediction and issues a registered PC redirect and flush on a mispredict.
- Owns the 2-bit-counter branch history table (BHT) that supplies the IF-stage prediction, plus the branch and mispredict statistics counters.

Parameters:
XLEN, 32, datapath/PC width
BHT_ENTRIES, 16, number of 2-bit counters; power of two, minimum 2
INDEX_LSB, 2, lowest PC bit used for the BHT index

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
if_pc  input  XLEN  fetch-stage PC for prediction lookup
if_pred_taken  output  1  combinational prediction for if_pc
ex_valid  input  1  EX-stage slot holds a valid instruction
ex_is_branch  input  1  EX instruction is a conditional branch
ex_funct3  input  3  branch funct3
ex_pc  input  XLEN  PC of the EX branch
ex_target  input  XLEN  computed branch target
ex_pred_taken  input  1  prediction carried down the pipe with this branch
BrUn  output  1  unsigned-compare select to the comparator
BrEq  input  1  comparator equal result
BrLt  input  1  comparator less-than result
redirect_valid  output  1  one-cycle pulse: fetch must load redirect_pc
redirect_pc  output  XLEN  corrected fetch PC
flush  output  1  kill IF/ID wrong-path instructions; equals redirect_valid
illegal_branch  output  1  one-cycle pulse: funct3 010/011 seen
branch_count  output  32  resolved legal branches, wraps
mispredict_count  output  32  mispredicted branches, wraps

Behaviour:
- Reset (async, rst_n=0):
  - redirect_valid, flush and illegal_branch go to 0; redirect_pc goes to 0.
  - Both counters go to 0.
  - Every BHT entry goes to 2'b01 (weakly not-taken).
  - A reset asserted mid-pulse kills the pulse immediately.
- BrUn = ex_funct3[1], purely combinational; it is valid in every cycle regardless of ex_valid.
- resolve = ex_valid & ex_is_branch & ~redirect_valid. The EX instruction in a redirect cycle is wrong-path and is ignored: no redirect, no BHT update, no count.
- Taken decode:
  - 000 BEQ: BrEq
  - 001 BNE: ~BrEq
  - 100 BLT: BrLt
  - 101 BGE: ~BrLt
  - 110 BLTU: BrLt
  - 111 BGEU: ~BrLt
- Illegal funct3 (010/011) on resolve:
  - illegal_branch pulses the next cycle.
  - No redirect, no BHT update, no count.
- mispredict = resolve & legal & (taken != ex_pred_taken).
- Redirect latency is one cycle after resolve.
  - Registered redirect_valid = flush = 1 for exactly one cycle.
  - redirect_pc = taken ? ex_target : ex_pc + 4, computed modulo 2^XLEN, so 0xFFFFFFFC+4 = 0x00000000.
  - Correctly predicted branches produce no redirect.
- BHT:
  - index = pc[INDEX_LSB +: log2(BHT_ENTRIES)].
  - if_pred_taken = MSB of entry[index(if_pc)], combinational.
  - On a legal resolve, entry[index(ex_pc)] saturates: +1 if taken, max 11; -1 if not taken, min 00.
  - The write takes effect at the clock edge. A same-cycle IF lookup of the same index returns the pre-update value; no bypass.
- Counters:
  - branch_count +1 per legal resolve.
  - mispredict_count +1 per mispredict.
  - Both wrap 0xFFFFFFFF to 0.
- Back-to-back:
  - Resolves on consecutive cycles are each handled when neither falls in a redirect cycle.
  - A resolve in cycle N+1 after a mispredict in N is suppressed, per the resolve rule.

Test Plan:
1. Reset, then if_pc=0x00000000 -> if_pred_taken=0; all outputs 0.
2. BEQ at ex_pc=0x100, target 0x200, BrEq=1, pred=0 -> next cycle redirect_valid=flush=1, redirect_pc=0x200, mispredict_count=1, branch_count=1; pulse lasts exactly one cycle.
3. BGEU funct3=111, BrLt=0, pred=1 -> BrUn=1 combinationally; no redirect; branch_count +1, mispredict_count unchanged.
4. BLT at ex_pc=0xFFFFFFFC, BrLt=0, pred=1 -> redirect_pc=0x00000000.
5. Same PC 0x40 resolved taken three times -> entry goes 01->10->11->11; if_pc=0x40 reads 1 after the first update, and reads 0 in the same cycle as the first update.
6. Mispredict in cycle N with ex_valid=1 branch in N+1 -> N+1 ignored, no second pulse. Also: funct3=010 -> illegal_branch pulse, counts unchanged. Also: rst_n low during a redirect pulse -> redirect_valid drops without waiting for a clock edge.
